// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed program image byte stream, writes 32-bit words into
// instruction memory and releases the core from reset once the checksum verifies.
module imem_boot_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [16:0] Capacity = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    StCntLo,
    StCntHi,
    StData,
    StCsum,
    StRun,
    StErr
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       word_q, word_d;
  logic [7:0]        acc_q, acc_d;
  logic [31:0]       timer_q, timer_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic              xfer;
  logic              receiving;
  logic              timed_out;
  logic [15:0]       hdr_count;
  logic              last_word;

  assign receiving = (state_q == StCntLo) || (state_q == StCntHi) ||
                     (state_q == StData)  || (state_q == StCsum);
  assign xfer      = rx_valid && receiving;
  assign hdr_count = {rx_data, count_q[7:0]};
  // A transfer in the expiry cycle takes priority over the timeout.
  assign timed_out = (TIMEOUT != 0) && !xfer && (state_q != StCntLo) && receiving &&
                     (timer_q == 32'(TIMEOUT - 1));
  // words_loaded has already caught up with the previous word: lane-3 bytes are 4 cycles apart.
  assign last_word = (17'(wl_q) + 17'd1) == {1'b0, count_q};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lane_d  = lane_q;
    word_d  = word_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wl_d    = wl_q;
    timer_d = timer_q;

    if (xfer || state_q == StCntLo) begin
      timer_d = '0;
    end else if (receiving) begin
      timer_d = timer_q + 32'd1;
    end

    unique case (state_q)
      StCntLo: begin
        if (xfer) begin
          count_d = {8'h00, rx_data};
          state_d = StCntHi;
        end
      end
      StCntHi: begin
        if (xfer) begin
          count_d = hdr_count;
          if (hdr_count == 16'd0) begin
            state_d = StCsum;
          end else if ({1'b0, hdr_count} > Capacity) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          acc_d  = acc_q + rx_data;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = wl_q[ADDR_W-1:0];
            wdata_d = {rx_data, word_q};
            wl_d    = wl_q + 1'b1;
            if (last_word) begin
              state_d = StCsum;
            end
          end else begin
            word_d[8*lane_q +: 8] = rx_data;
          end
        end
      end
      StCsum: begin
        if (xfer) begin
          state_d = (rx_data == acc_q) ? StRun : StErr;
        end
      end
      StRun:   ;
      StErr:   ;
      default: state_d = StErr;
    endcase

    if (timed_out) begin
      state_d = StErr;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StCntLo;
      count_q <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      acc_q   <= '0;
      timer_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wl_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      acc_q   <= acc_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wl_q    <= wl_d;
    end
  end

  assign rx_ready     = receiving;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign done         = (state_q == StRun);
  assign error        = (state_q == StErr);
  assign core_rst_n   = (state_q == StRun);
  assign words_loaded = wl_q;

endmodule
